branch_predictor: RTL and testbench

- Parametrised branch target buffer with saturating-counter direction prediction for the pipelined MIPS core.
- Next generation of the always-PC+4 fetch: IF looks up the current PC in the same cycle and gets a predicted next PC.
- The EX/MEM stage writes back the resolved outcome. The block flags mispredictions so the datapath can flush IF/ID and ID/EX.
- Keeps lookup and mispredict statistics for performance counters.

---
 rtl/branch_predictor_pkg.sv | 15 +
 rtl/branch_predictor_sat_counter.sv | 27 ++
 rtl/branch_predictor.sv | 167 ++++++++++++++++
 tb/tb_branch_predictor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch target buffer / direction predictor.
//   PRED_MODE_*  : predictor operating modes (static not-taken, dynamic)
//   cnt_op_e     : saturating counter operation selector
package branch_predictor_pkg;

    localparam int unsigned PRED_MODE_STATIC  = 0;
    localparam int unsigned PRED_MODE_DYNAMIC = 1;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-value for a CNT_W-bit saturating counter.
//   cnt_i : current counter value
//   op_i  : hold / increment (saturate at max) / decrement (saturate at 0)
//   cnt_c : next counter value
module branch_predictor_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  cnt_op_e          op_i,
    output logic [CNT_W-1:0] cnt_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    always_comb begin
        cnt_c = cnt_i;
        case (op_i)
            CNT_INC: if (cnt_i != CNT_MAX) cnt_c = cnt_i + CNT_W'(1);
            CNT_DEC: if (cnt_i != CNT_MIN) cnt_c = cnt_i - CNT_W'(1);
            default: cnt_c = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction.
// Fetch looks up its PC combinationally (zero latency); EX/MEM writes back
// the resolved outcome and receives a flush request plus redirect PC.
//   CLK, RST           : clock, synchronous active-high reset
//   lookup_pc/_en      : fetch PC, fetch-advancing qualifier (stats only)
//   pred_hit/_taken/_target : lookup result, target = lookup_pc+4 when not taken
//   update_*           : resolved branch/jump from EX/MEM
//   mispredict, correct_pc  : flush request and redirect PC
//   stat_lookups, stat_mispredicts : free-running wrap-around counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned MODE    = 1,
    parameter int unsigned WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] lookup_pc,
    input  logic              lookup_en,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [WORD_W-1:0] pred_target,
    input  logic              update_en,
    input  logic [WORD_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [WORD_W-1:0] update_target,
    input  logic              update_pred_taken,
    input  logic [WORD_W-1:0] update_pred_target,
    output logic              mispredict,
    output logic [WORD_W-1:0] correct_pc,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
);

    localparam int unsigned IDX_W    = $clog2(ENTRIES);
    localparam int unsigned TAG_W    = WORD_W - IDX_W - 2;
    localparam int unsigned CNT_HALF = 1 << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(CNT_HALF);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(CNT_HALF - 1);
    localparam bit DYN = (MODE == PRED_MODE_DYNAMIC);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] target;
        logic [CNT_W-1:0]  cnt;
    } btb_entry_t;

    localparam btb_entry_t ENTRY_RST = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        cnt:    CNT_WEAK_NT
    };

    // Elaboration-time parameter sanity checks
    if (ENTRIES < 2 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
        $error("branch_predictor: ENTRIES must be a power of 2, >= 2");
    end
    if (CNT_W < 1 || CNT_W > 4) begin : g_bad_cnt_w
        $error("branch_predictor: CNT_W must be 1..4");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("branch_predictor: MODE must be 0 or 1");
    end

    btb_entry_t btb_q [ENTRIES];
    btb_entry_t btb_d [ENTRIES];
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    btb_entry_t        lk_entry, up_entry;
    logic              up_hit;
    logic [WORD_W-1:0] actual_next;
    cnt_op_e           cnt_op;
    logic [CNT_W-1:0]  cnt_nxt;

    // Byte-offset bits and the carried prediction bit do not affect the result
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_pred_taken};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[WORD_W-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[WORD_W-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed
    always_comb begin
        lk_entry    = btb_q[lk_idx];
        pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
        pred_taken  = DYN && pred_hit && lk_entry.cnt[CNT_W-1];
        pred_target = pred_taken ? lk_entry.target : lookup_pc + WORD_W'(4);
    end

    // Resolution check against the prediction carried down the pipe
    always_comb begin
        actual_next = update_taken ? update_target : update_pc + WORD_W'(4);
        mispredict  = update_en && (update_pred_target != actual_next);
        correct_pc  = update_en ? actual_next : '0;
    end

    // Direction counter step for the entry being updated
    always_comb begin
        up_entry = btb_q[up_idx];
        up_hit   = up_entry.valid && (up_entry.tag == up_tag);
        cnt_op   = CNT_HOLD;
        if (update_en && DYN && up_hit) begin
            cnt_op = update_taken ? CNT_INC : CNT_DEC;
        end
    end

    branch_predictor_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .cnt_i (up_entry.cnt),
        .op_i  (cnt_op),
        .cnt_c (cnt_nxt)
    );

    // Table write: train on hit, allocate weakly-taken on a taken miss
    always_comb begin
        btb_d = btb_q;
        if (update_en && DYN) begin
            if (up_hit) begin
                btb_d[up_idx].cnt = cnt_nxt;
                if (update_taken) begin
                    btb_d[up_idx].target = update_target;
                end
            end else if (update_taken) begin
                btb_d[up_idx] = '{
                    valid:  1'b1,
                    tag:    up_tag,
                    target: update_target,
                    cnt:    CNT_WEAK_T
                };
            end
        end
    end

    always_comb begin
        stat_lookups_d     = stat_lookups_q + 32'(lookup_en);
        stat_mispredicts_d = stat_mispredicts_q + 32'(mispredict);
    end

    // Reset dominates any concurrent update
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb_q[i] <= ENTRY_RST;
            end
            stat_lookups_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            btb_q              <= btb_d;
            stat_lookups_q     <= stat_lookups_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a dynamic (MODE=1) and a static (MODE=0) predictor share
// stimulus; expected results are queued per step and checked mid-cycle.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        lookup_en;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic [31:0] update_pred_target;

    logic        d_hit, d_taken, d_mis;
    logic [31:0] d_target, d_cpc, d_lk, d_mp;
    logic        s_hit, s_taken, s_mis;
    logic [31:0] s_target, s_cpc, s_lk, s_mp;

    int total = 0;
    int bad   = 0;

    int unsigned m_lk = 0;
    int unsigned m_mp = 0;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] cpc;
        logic [31:0] lk;
        logic [31:0] mp;
        logic [31:0] s_target;
    } exp_t;

    exp_t exp_q[$];

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(1), .WORD_W(32)) u_dut (
        .CLK(clk), .RST(rst),
        .lookup_pc(lookup_pc), .lookup_en(lookup_en),
        .pred_hit(d_hit), .pred_taken(d_taken), .pred_target(d_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target),
        .mispredict(d_mis), .correct_pc(d_cpc),
        .stat_lookups(d_lk), .stat_mispredicts(d_mp)
    );

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(0), .WORD_W(32)) u_dut_static (
        .CLK(clk), .RST(rst),
        .lookup_pc(lookup_pc), .lookup_en(lookup_en),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target),
        .mispredict(s_mis), .correct_pc(s_cpc),
        .stat_lookups(s_lk), .stat_mispredicts(s_mp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check mid-cycle
    task automatic step(input logic [31:0] lpc, input logic len,
                        input logic uen, input logic [31:0] upc, input logic utk,
                        input logic [31:0] utgt, input logic [31:0] uptgt,
                        input logic e_hit, input logic e_tk, input logic [31:0] e_tgt,
                        input logic e_mis, input logic [31:0] e_cpc);
        exp_t e;
        exp_t got;
        @(negedge clk);
        lookup_pc          = lpc;
        lookup_en          = len;
        update_en          = uen;
        update_pc          = upc;
        update_taken       = utk;
        update_target      = utgt;
        update_pred_target = uptgt;
        update_pred_taken  = (uptgt != upc + 32'd4);
        e.hit      = e_hit;
        e.taken    = e_tk;
        e.target   = e_tgt;
        e.mis      = e_mis;
        e.cpc      = e_cpc;
        e.lk       = 32'(m_lk);
        e.mp       = 32'(m_mp);
        e.s_target = lpc + 32'd4;
        exp_q.push_back(e);
        #2;
        got = exp_q.pop_front();
        check("pred_hit",        32'(d_hit),    32'(got.hit));
        check("pred_taken",      32'(d_taken),  32'(got.taken));
        check("pred_target",     d_target,      got.target);
        check("mispredict",      32'(d_mis),    32'(got.mis));
        check("correct_pc",      d_cpc,         got.cpc);
        check("stat_lookups",    d_lk,          got.lk);
        check("stat_mispredicts", d_mp,         got.mp);
        check("static_hit",      32'(s_hit),    32'd0);
        check("static_taken",    32'(s_taken),  32'd0);
        check("static_target",   s_target,      got.s_target);
        check("static_mispredict", 32'(s_mis),  32'(got.mis));
        check("static_correct_pc", s_cpc,       got.cpc);
        check("static_lookups",  s_lk,          got.lk);
        check("static_mispredicts", s_mp,       got.mp);
        if (len) m_lk++;
        if (e_mis) m_mp++;
    endtask

    task automatic idle_inputs();
        lookup_pc          = 32'h0;
        lookup_en          = 1'b0;
        update_en          = 1'b0;
        update_pc          = 32'h0;
        update_taken       = 1'b0;
        update_target      = 32'h0;
        update_pred_taken  = 1'b0;
        update_pred_target = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //    lpc  len  uen  upc  tk  utgt  uptgt        hit tk  tgt  mis cpc
        // Cold lookup after reset
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 32'h44, 0, 32'h0);
        // Taken miss allocates; lookup same cycle still sees empty entry
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 32'h44,   0, 0, 32'h44, 1, 32'h100);
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   32'h0,    1, 1, 32'h100, 0, 32'h0);
        // Correct predictions train counter 2->3->3->3
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 32'h100,  1, 1, 32'h100, 0, 32'h100);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 32'h100,  1, 1, 32'h100, 0, 32'h100);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 32'h100,  1, 1, 32'h100, 0, 32'h100);
        // Not-taken: 3->2 (still taken), 2->1
        step(32'h40, 1, 1, 32'h40, 0, 32'h100, 32'h100,  1, 1, 32'h100, 1, 32'h44);
        step(32'h40, 1, 1, 32'h40, 0, 32'h100, 32'h100,  1, 1, 32'h100, 1, 32'h44);
        // Counter 1: not taken; 1->0, then saturates at 0
        step(32'h40, 1, 1, 32'h40, 0, 32'h100, 32'h44,   1, 0, 32'h44, 0, 32'h44);
        step(32'h40, 1, 1, 32'h40, 0, 32'h100, 32'h44,   1, 0, 32'h44, 0, 32'h44);
        // Counter 0->1->2
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 32'h44,   1, 0, 32'h44, 1, 32'h100);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 32'h44,   1, 0, 32'h44, 1, 32'h100);
        // Hit-taken update replaces the target
        step(32'h40, 1, 1, 32'h40, 1, 32'h200, 32'h100,  1, 1, 32'h100, 1, 32'h200);
        // Alias 0x80 evicts 0x40 (same index, different tag)
        step(32'h40, 1, 1, 32'h80, 1, 32'h300, 32'h84,   1, 1, 32'h200, 1, 32'h300);
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 32'h44, 0, 32'h0);
        step(32'h80, 1, 0, 32'h0,  0, 32'h0,   32'h0,    1, 1, 32'h300, 0, 32'h0);
        // PC+4 wraps; lookup_en low leaves stats alone
        step(32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        // update_en low: no flush, correct_pc 0, no table change
        step(32'h80, 0, 0, 32'h80, 1, 32'h500, 32'h84,   1, 1, 32'h300, 0, 32'h0);
        step(32'h80, 1, 0, 32'h0,  0, 32'h0,   32'h0,    1, 1, 32'h300, 0, 32'h0);

        // Reset with a concurrent update: update discarded, table and stats cleared
        @(negedge clk);
        rst                = 1'b1;
        lookup_en          = 1'b1;
        update_en          = 1'b1;
        update_pc          = 32'h40;
        update_taken       = 1'b1;
        update_target      = 32'h100;
        update_pred_target = 32'h44;
        update_pred_taken  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        m_lk = 0;
        m_mp = 0;

        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 32'h44, 0, 32'h0);
        step(32'h80, 1, 0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 32'h84, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
